// File: rtl/mux_n1_stream_pkg.sv
// Shared constants and helpers for the N:1 streaming multiplexer.
package mux_pkg;

    localparam int unsigned MODE_SEL = 0;
    localparam int unsigned MODE_RR  = 1;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_n1_stream_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr, else lowest overall.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    logic            hi_vld;
    logic [SELW-1:0] hi_idx;
    logic [SELW-1:0] lo_idx;

    // Two-pass scan replaces a wrapped search, so no modulo of N is needed.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (req[i-1]) begin
                lo_idx = SELW'(i - 1);
                if (SELW'(i - 1) >= ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = SELW'(i - 1);
                end
            end
        end
        gnt_vld = |req;
        gnt_idx = hi_vld ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/mux_n1_stream.sv
// N:1 W-bit valid/ready multiplexer with one registered output stage.
// MODE selects SEL-driven choice or round-robin arbitration among valid inputs.
module mux_n1_stream
    import mux_pkg::*;
#(
    parameter  int unsigned N    = 4,
    parameter  int unsigned W    = 8,
    parameter  int unsigned MODE = MODE_SEL,
    localparam int unsigned SELW = clog2_min1(N)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N*W-1:0]    IN_DATA,
    input  logic [N-1:0]      IN_VALID,
    output logic [N-1:0]      IN_READY,
    input  logic [SELW-1:0]   SEL,
    output logic [W-1:0]      Z,
    output logic              Z_VALID,
    input  logic              Z_READY,
    output logic [SELW-1:0]   Z_SRC
);

    logic            ld;
    logic            tx;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic [W-1:0]    gnt_data;

    assign ld = !Z_VALID | Z_READY;

    if (MODE == MODE_RR) begin : g_rr
        logic [SELW-1:0] ptr;

        rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
            .req     (IN_VALID),
            .ptr     (ptr),
            .gnt_vld (gnt_vld),
            .gnt_idx (gnt_idx)
        );

        always_ff @(posedge CLK) begin
            if (RST) begin
                ptr <= '0;
            end else if (tx) begin
                ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
            end
        end
    end else if (N == 1) begin : g_single
        assign gnt_vld = 1'b1;
        assign gnt_idx = '0;
    end else begin : g_sel
        assign gnt_vld = 32'(SEL) < N;
        assign gnt_idx = SEL;
    end

    always_comb begin
        IN_READY = '0;
        for (int unsigned i = 0; i < N; i++) begin
            IN_READY[i] = ld & gnt_vld & (gnt_idx == SELW'(i)) & !RST;
        end
    end

    assign tx = |(IN_READY & IN_VALID);

    // Decoded mux keeps an out-of-range SEL from indexing past IN_DATA.
    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_idx == SELW'(i)) gnt_data = IN_DATA[i*W +: W];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Z       <= '0;
            Z_VALID <= 1'b0;
            Z_SRC   <= '0;
        end else if (tx) begin
            Z       <= gnt_data;
            Z_VALID <= 1'b1;
            Z_SRC   <= gnt_idx;
        end else if (Z_READY) begin
            Z_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n1_stream.sv
// Self-checking bench: four builds (N=4 sel, N=4 round-robin, N=5 sel, N=1 sel) against a queue-free reference model.
module tb_mux_n1_stream;

    logic        clk;
    logic        rst;
    logic [63:0] d  [4];
    logic [7:0]  v  [4];
    logic [2:0]  s  [4];
    logic        zr [4];

    logic [3:0] rdy0, rdy1;
    logic [4:0] rdy2;
    logic [0:0] rdy3;
    logic [7:0] z0, z1, z2, z3;
    logic       zv0, zv1, zv2, zv3;
    logic [1:0] zs0, zs1;
    logic [2:0] zs2;
    logic [0:0] zs3;

    int unsigned tests = 0;
    int unsigned fails = 0;

    int unsigned n_of    [4] = '{4, 4, 5, 1};
    int unsigned mode_of [4] = '{0, 1, 0, 0};
    int unsigned mz [4];
    int unsigned mv [4];
    int unsigned ms [4];
    int unsigned mp [4];
    logic [7:0]  pre_rdy [4];

    mux_n1_stream #(.N(4), .W(8), .MODE(0)) dut0 (
        .CLK(clk), .RST(rst), .IN_DATA(d[0][31:0]), .IN_VALID(v[0][3:0]), .IN_READY(rdy0),
        .SEL(s[0][1:0]), .Z(z0), .Z_VALID(zv0), .Z_READY(zr[0]), .Z_SRC(zs0));
    mux_n1_stream #(.N(4), .W(8), .MODE(1)) dut1 (
        .CLK(clk), .RST(rst), .IN_DATA(d[1][31:0]), .IN_VALID(v[1][3:0]), .IN_READY(rdy1),
        .SEL(s[1][1:0]), .Z(z1), .Z_VALID(zv1), .Z_READY(zr[1]), .Z_SRC(zs1));
    mux_n1_stream #(.N(5), .W(8), .MODE(0)) dut2 (
        .CLK(clk), .RST(rst), .IN_DATA(d[2][39:0]), .IN_VALID(v[2][4:0]), .IN_READY(rdy2),
        .SEL(s[2][2:0]), .Z(z2), .Z_VALID(zv2), .Z_READY(zr[2]), .Z_SRC(zs2));
    mux_n1_stream #(.N(1), .W(8), .MODE(0)) dut3 (
        .CLK(clk), .RST(rst), .IN_DATA(d[3][7:0]), .IN_VALID(v[3][0:0]), .IN_READY(rdy3),
        .SEL(s[3][0:0]), .Z(z3), .Z_VALID(zv3), .Z_READY(zr[3]), .Z_SRC(zs3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, id, act, exp, $time);
        end
    endtask

    task automatic get_act(input int id, output logic [7:0] r, output logic [7:0] z,
                           output logic zv, output logic [2:0] zs);
        case (id)
            0: begin r = 8'(rdy0); z = z0; zv = zv0; zs = 3'(zs0); end
            1: begin r = 8'(rdy1); z = z1; zv = zv1; zs = 3'(zs1); end
            2: begin r = 8'(rdy2); z = z2; zv = zv2; zs = zs2;     end
            default: begin r = 8'(rdy3); z = z3; zv = zv3; zs = 3'(zs3); end
        endcase
    endtask

    // Grant from the rules: SEL index (if in range) or first valid in rotated order.
    task automatic model_grant(input int id, output bit found, output int unsigned g);
        found = 0;
        g = 0;
        if (mode_of[id] == 0) begin
            if (n_of[id] == 1) begin
                found = 1;
            end else if (s[id] < n_of[id]) begin
                found = 1;
                g = s[id];
            end
        end else begin
            for (int unsigned k = 0; k < n_of[id]; k++) begin
                int unsigned idx;
                idx = (mp[id] + k) % n_of[id];
                if (!found && v[id][idx]) begin
                    found = 1;
                    g = idx;
                end
            end
        end
    endtask

    // One clock: check IN_READY before the edge, outputs after it, for every build.
    task automatic step();
        bit          etx [4];
        int unsigned eg  [4];
        logic [7:0]  r, z;
        logic        zv;
        logic [2:0]  zs;
        #1;
        for (int id = 0; id < 4; id++) begin
            bit found, ld;
            int unsigned g;
            logic [7:0] er;
            model_grant(id, found, g);
            ld = (mv[id] == 0) || zr[id];
            er = (ld && found && !rst) ? 8'(1 << g) : 8'h00;
            get_act(id, r, z, zv, zs);
            pre_rdy[id] = r;
            chk("in_ready", id, 32'(r), 32'(er));
            etx[id] = ld && found && !rst && v[id][g];
            eg[id]  = g;
        end
        @(posedge clk);
        #1;
        for (int id = 0; id < 4; id++) begin
            if (rst) begin
                mz[id] = 0; mv[id] = 0; ms[id] = 0; mp[id] = 0;
            end else if (etx[id]) begin
                mz[id] = d[id][eg[id]*8 +: 8];
                ms[id] = eg[id];
                mv[id] = 1;
                if (mode_of[id] == 1) mp[id] = (eg[id] + 1) % n_of[id];
            end else if (zr[id]) begin
                mv[id] = 0;
            end
            get_act(id, r, z, zv, zs);
            chk("z", id, 32'(z), mz[id]);
            chk("z_valid", id, 32'(zv), mv[id]);
            chk("z_src", id, 32'(zs), ms[id]);
        end
    endtask

    typedef struct {
        bit          rst;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  valid;
        bit          zr;
        logic [3:0]  e_rdy;
        logic [7:0]  e_z;
        bit          e_zv;
        logic [1:0]  e_src;
    } vec_t;

    vec_t tbl [11];

    task automatic rr_expect(input logic [3:0] valid, input bit zrdy, input logic [1:0] e_src, input bit e_zv);
        v[1] = 8'(valid);
        zr[1] = zrdy;
        step();
        chk("rr_src", 1, 32'(zs1), 32'(e_src));
        chk("rr_valid", 1, 32'(zv1), 32'(e_zv));
    endtask

    initial begin
        for (int id = 0; id < 4; id++) begin
            d[id] = '0; v[id] = '0; s[id] = '0; zr[id] = 1'b1;
            mz[id] = 0; mv[id] = 0; ms[id] = 0; mp[id] = 0;
        end
        rst = 1'b1;

        //         rst sel  data          valid  zr  e_rdy  e_z    zv e_src
        tbl[0]  = '{1, 2'd0, 32'h33A52211, 4'hF, 1, 4'h0, 8'h00, 0, 2'd0};
        tbl[1]  = '{1, 2'd0, 32'h33A52211, 4'hF, 1, 4'h0, 8'h00, 0, 2'd0};
        tbl[2]  = '{0, 2'd2, 32'h33A52211, 4'hF, 1, 4'h4, 8'hA5, 1, 2'd2};
        tbl[3]  = '{0, 2'd0, 32'h33A52211, 4'hF, 1, 4'h1, 8'h11, 1, 2'd0};
        tbl[4]  = '{0, 2'd3, 32'h44556677, 4'hF, 0, 4'h0, 8'h11, 1, 2'd0};
        tbl[5]  = '{0, 2'd1, 32'h8899AABB, 4'hF, 0, 4'h0, 8'h11, 1, 2'd0};
        tbl[6]  = '{0, 2'd2, 32'h8899AABB, 4'hF, 0, 4'h0, 8'h11, 1, 2'd0};
        tbl[7]  = '{0, 2'd2, 32'h8899AABB, 4'hF, 1, 4'h4, 8'h99, 1, 2'd2};
        tbl[8]  = '{0, 2'd1, 32'h8899AABB, 4'h0, 1, 4'h2, 8'h99, 0, 2'd2};
        tbl[9]  = '{0, 2'd3, 32'h8899AABB, 4'hF, 0, 4'h8, 8'h88, 1, 2'd3};
        tbl[10] = '{1, 2'd3, 32'h8899AABB, 4'hF, 0, 4'h0, 8'h00, 0, 2'd0};

        v[1] = 8'h0F;
        for (int i = 0; i < 11; i++) begin
            rst   = tbl[i].rst;
            s[0]  = 3'(tbl[i].sel);
            d[0]  = 64'(tbl[i].data);
            v[0]  = 8'(tbl[i].valid);
            zr[0] = tbl[i].zr;
            if (i >= 2) v[1] = 8'h00;
            step();
            chk("tbl_ready", i, 32'(pre_rdy[0]), 32'(tbl[i].e_rdy));
            chk("tbl_z", i, 32'(z0), 32'(tbl[i].e_z));
            chk("tbl_zv", i, 32'(zv0), 32'(tbl[i].e_zv));
            chk("tbl_src", i, 32'(zs0), 32'(tbl[i].e_src));
        end
        rst = 1'b0;
        v[0] = '0;

        // Round-robin: full rotation, sparse requests, then pointer wrap cases.
        d[1] = 64'h0000_0000_DDCC_BBAA;
        for (int i = 0; i < 8; i++) rr_expect(4'hF, 1, 2'(i % 4), 1);
        for (int i = 0; i < 4; i++) rr_expect(4'hA, 1, (i % 2 == 0) ? 2'd1 : 2'd3, 1);
        rr_expect(4'h4, 1, 2'd2, 1);
        rr_expect(4'h1, 1, 2'd0, 1);
        rr_expect(4'hF, 1, 2'd1, 1);
        rr_expect(4'h4, 1, 2'd2, 1);
        rr_expect(4'h8, 1, 2'd3, 1);
        rr_expect(4'hF, 1, 2'd0, 1);
        rr_expect(4'h4, 1, 2'd2, 1);
        rr_expect(4'hF, 0, 2'd2, 1);
        chk("rr_stall_ready", 1, 32'(pre_rdy[1]), 32'h0);
        rst = 1'b1;
        rr_expect(4'hF, 0, 2'd0, 0);
        chk("rr_rst_z", 1, 32'(z1), 32'h0);
        rst = 1'b0;
        rr_expect(4'hE, 1, 2'd1, 1);
        chk("rr_post_rst_z", 1, 32'(z1), 32'hBB);
        v[1] = '0;

        // Five-channel select build: last valid index, then out-of-range SEL.
        d[2] = 64'h0000_005A_4433_2211;
        v[2] = 8'h1F;
        zr[2] = 1'b1;
        s[2] = 3'd4;
        step();
        chk("sel4_ready", 2, 32'(pre_rdy[2]), 32'h10);
        chk("sel4_z", 2, 32'(z2), 32'h5A);
        chk("sel4_src", 2, 32'(zs2), 32'd4);
        s[2] = 3'd5;
        step();
        chk("sel5_ready", 2, 32'(pre_rdy[2]), 32'h0);
        chk("sel5_zv", 2, 32'(zv2), 32'h0);
        chk("sel5_z", 2, 32'(z2), 32'h5A);
        s[2] = 3'd7;
        step();
        chk("sel7_ready", 2, 32'(pre_rdy[2]), 32'h0);

        // Randomized traffic against the model on every build.
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            for (int id = 0; id < 4; id++) begin
                d[id]  = {$urandom, $urandom};
                v[id]  = 8'($urandom);
                s[id]  = 3'($urandom);
                zr[id] = ($urandom_range(0, 3) != 0);
            end
            s[0] = 3'($urandom_range(0, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
